issue_ctrl: RTL and testbench
=============================

# issue_ctrl

In-order dual-issue scheduler for the superscalar core. Buffers decoded instructions in a small FIFO and drives the 2-wide scoreboard query ports each cycle. Combines the scoreboard hazard results with intra-pair dependency checks and execute-unit readiness, then issues 0, 1 or 2 instructions per cycle strictly in program order.

## Interface

Parameters:
- DEPTH, 4: instruction buffer entries; power of two, at least 2.
- OP_W, 32: opaque payload width (opcode, immediates, PC) carried alongside each instruction.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  discard all buffered instructions.
- in_valid[1:0]  in  1 each  decode slot valid; in_valid[1] implies in_valid[0].
- in_ready  out  1  buffer can accept a full pair this cycle.
- in_rs1[1:0], in_rs2[1:0], in_rd[1:0]  in  5 each  register fields; slot 0 is older.
- in_op[1:0]  in  OP_W each  payload.
- sb_issue_valid[1:0]  out  1 each  instruction issued this cycle; marks its rd busy.
- sb_rs1[1:0], sb_rs2[1:0], sb_rd[1:0]  out  5 each  scoreboard query fields.
- sb_hazard[1:0]  in  1 each  combinational hazard result for the corresponding query.
- ex_valid[1:0]  out  1 each  issue to execute pipe 0/1.
- ex_ready[1:0]  in  1 each  execute pipe can accept.
- ex_rd[1:0]  out  5 each;  ex_op[1:0]  out  OP_W each  issued destination and payload.

## Operation

- FIFO with rd_ptr, wr_ptr and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Enqueue: when in_valid[0] && in_ready, write slot 0 at wr_ptr and slot 1 (if in_valid[1]) at wr_ptr+1. wr_ptr advances by 1 or 2.
- in_ready = (DEPTH - count >= 2) && !flush. It is computed from registered count only; same-cycle dequeues are not credited.
- Query: entry H0 = head and H1 = head+1 always drive sb_rs1/rs2/rd[0]/[1], whether or not the entries are valid. v0 = count>=1, v1 = count>=2.
- issue0 = v0 && !sb_hazard[0] && ex_ready[0] && !flush.
- issue1 = issue0 && v1 && !sb_hazard[1] && ex_ready[1] && !dep.
- dep = (H0.rd != 0) && (H1.rs1 == H0.rd || H1.rs2 == H0.rd || H1.rd == H0.rd). This covers RAW and WAW within the pair, which the scoreboard cannot see until the next cycle.
- H1 never issues without H0, which preserves in-order issue. H0 always goes to pipe 0 and H1 to pipe 1.
- ex_valid[i] = sb_issue_valid[i] = issue_i. ex_rd/ex_op mirror Hi.
- Dequeue: rd_ptr += issue0 + issue1.
- Update: count_next = count + enq_n - deq_n.
- flush: rd_ptr, wr_ptr and count are cleared at the next edge. No issue and no enqueue occur in the flush cycle.

## Timing

- Reset values: count=0, pointers=0, in_ready=1, ex_valid=0, sb_issue_valid=0. When count=0, ex_rd, ex_op and sb_* fields are don't-care but driven from the storage array with no X-gating.
- Enqueue-to-issue latency is 1 cycle minimum; there is no bypass from in_* to ex_*.
- Issue is combinational from registered state, sb_hazard and ex_ready. A handshake completes when ex_valid && ex_ready.
- Empty: no issue. Full (count=DEPTH): in_ready=0. Count=DEPTH-1: in_ready=0 even though a single slot is free.
- Simultaneous enqueue of 2 and dequeue of 2 at count=2: count stays 2, and pointers wrap correctly.
- Reset asserted mid-operation: the buffer empties immediately and asynchronously, and outputs return to their reset values.

## Configuration

- ISSUE_CTRL_PERF_EN defined: adds outputs perf_issued (32 bits), perf_stall_hazard (32 bits) and perf_stall_struct (32 bits). All reset to 0 and saturate at all-ones.
  - perf_issued += issue0 + issue1.
  - perf_stall_hazard increments on cycles with v0 && (sb_hazard[0] || (issue0 && v1 && (sb_hazard[1] || dep))).
  - perf_stall_struct increments on cycles with v0 && !sb_hazard[0] && !ex_ready[0].
- ISSUE_CTRL_PERF_EN undefined: counters and ports are absent, with no other behavioural change.

## Structure

- Shared package superscalar_pkg holds:
  - ISSUE_W=2 and REG_IDX_W=5.
  - issue_entry_t, a struct of rs1, rs2, rd and op.
- Sub-module issue_fifo: dual-write/dual-read circular buffer exposing heads H0/H1, count, enq_n and deq_n.
- issue_ctrl holds the issue logic and the optional counters.

## Test plan

- Independent pair: enqueue (x1←x2,x3), (x4←x5,x6) with sb_hazard=0 and ex_ready=11 → next cycle ex_valid=11, sb_issue_valid=11, count back to 0.
- Intra-pair RAW: enqueue (x1←..), (x7←x1,x0) → pair issue cycle: only slot 0 issues. Next cycle H1 is at the head and sb_hazard[0]=1 is reflected as a stall, with no issue.
- Scoreboard hazard on slot 0 with sb_hazard=01 → ex_valid=00; slot 1 is not issued out of order.
- Fill: 2 pairs into DEPTH=4 → in_ready=0. One issue → in_ready still 0 (count=3). Second issue → in_ready=1. Pointer wrap verified after 3 full rounds.
- flush with count=3 and ex_ready=11 → ex_valid=00 that cycle, count=0 and in_ready=1 the next cycle.
- Reset asserted mid-stream between clock edges → ex_valid drops immediately; with ISSUE_CTRL_PERF_EN, perf_issued reads 0.

Source files
------------

// File: rtl/superscalar_pkg.sv
// Shared types for the superscalar front end: issue width, register index width
// and the buffered instruction entry.
package superscalar_pkg;

  localparam int ISSUE_W   = 2;
  localparam int REG_IDX_W = 5;
  // Entry payload storage width; issue_ctrl instances use OP_W <= OP_MAX_W.
  localparam int OP_MAX_W  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [OP_MAX_W-1:0]  op;
  } issue_entry_t;

  // Number of set bits in a 2-wide valid/issue vector.
  function automatic logic [1:0] slotCount(input logic [ISSUE_W-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Dual-write / dual-read circular instruction buffer. Exposes the two oldest
// entries (H0, H1) and the occupancy count; the caller decides enq/deq amounts.
module issue_fifo
  import superscalar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               i_enq_n,
  input  issue_entry_t             i_wr0,
  input  issue_entry_t             i_wr1,
  input  logic [1:0]               i_deq_n,
  output issue_entry_t             o_h0,
  output issue_entry_t             o_h1,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  issue_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr1;
  logic [PTR_W-1:0] w_rd_ptr1;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_enq_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_deq_n);
      r_count  <= r_count + CNT_W'(i_enq_n) - CNT_W'(i_deq_n);
    end
  end

  // Storage is not reset: entries beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (!flush && i_enq_n != 2'd0) begin
      r_mem[r_wr_ptr] <= i_wr0;
      if (i_enq_n == 2'd2) begin
        r_mem[w_wr_ptr1] <= i_wr1;
      end
    end
  end

  assign o_h0    = r_mem[r_rd_ptr];
  assign o_h1    = r_mem[w_rd_ptr1];
  assign o_count = r_count;

endmodule

// File: rtl/issue_ctrl.sv
// In-order dual-issue scheduler: buffers decoded pairs, queries the scoreboard
// and issues 0/1/2 instructions per cycle. Define ISSUE_CTRL_PERF_EN for perf counters.
module issue_ctrl
  import superscalar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [1:0]                     in_valid,
  output logic                           in_ready,
  input  logic [1:0][REG_IDX_W-1:0]      in_rs1,
  input  logic [1:0][REG_IDX_W-1:0]      in_rs2,
  input  logic [1:0][REG_IDX_W-1:0]      in_rd,
  input  logic [1:0][OP_W-1:0]           in_op,
  output logic [1:0]                     sb_issue_valid,
  output logic [1:0][REG_IDX_W-1:0]      sb_rs1,
  output logic [1:0][REG_IDX_W-1:0]      sb_rs2,
  output logic [1:0][REG_IDX_W-1:0]      sb_rd,
  input  logic [1:0]                     sb_hazard,
  output logic [1:0]                     ex_valid,
  input  logic [1:0]                     ex_ready,
  output logic [1:0][REG_IDX_W-1:0]      ex_rd,
  output logic [1:0][OP_W-1:0]           ex_op
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_issued,
  output logic [31:0]                    perf_stall_hazard,
  output logic [31:0]                    perf_stall_struct
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  issue_entry_t     w_wr0;
  issue_entry_t     w_wr1;
  issue_entry_t     w_h0;
  issue_entry_t     w_h1;
  logic [CNT_W-1:0] w_count;
  logic [1:0]       w_enq_n;
  logic [1:0]       w_deq_n;
  logic             w_v0;
  logic             w_v1;
  logic             w_dep;
  logic             w_issue0;
  logic             w_issue1;

  assign w_wr0 = '{rs1: in_rs1[0], rs2: in_rs2[0], rd: in_rd[0], op: OP_MAX_W'(in_op[0])};
  assign w_wr1 = '{rs1: in_rs1[1], rs2: in_rs2[1], rd: in_rd[1], op: OP_MAX_W'(in_op[1])};

  // Ready only if a whole pair fits, judged on registered occupancy alone.
  assign in_ready = (w_count <= CNT_W'(DEPTH - 2)) && !flush;

  always_comb begin
    w_enq_n = 2'd0;
    if (in_valid[0] && in_ready) begin
      w_enq_n = in_valid[1] ? 2'd2 : 2'd1;
    end
  end

  assign w_v0 = (w_count >= CNT_W'(1));
  assign w_v1 = (w_count >= CNT_W'(2));

  // RAW/WAW inside the pair is invisible to the scoreboard until next cycle.
  assign w_dep = (w_h0.rd != '0) &&
                 ((w_h1.rs1 == w_h0.rd) || (w_h1.rs2 == w_h0.rd) || (w_h1.rd == w_h0.rd));

  assign w_issue0 = w_v0 && !sb_hazard[0] && ex_ready[0] && !flush;
  assign w_issue1 = w_issue0 && w_v1 && !sb_hazard[1] && ex_ready[1] && !w_dep;

  assign w_deq_n = slotCount({w_issue1, w_issue0});

  issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_enq_n (w_enq_n),
    .i_wr0   (w_wr0),
    .i_wr1   (w_wr1),
    .i_deq_n (w_deq_n),
    .o_h0    (w_h0),
    .o_h1    (w_h1),
    .o_count (w_count)
  );

  assign sb_rs1[0] = w_h0.rs1;
  assign sb_rs2[0] = w_h0.rs2;
  assign sb_rd[0]  = w_h0.rd;
  assign sb_rs1[1] = w_h1.rs1;
  assign sb_rs2[1] = w_h1.rs2;
  assign sb_rd[1]  = w_h1.rd;

  assign sb_issue_valid = {w_issue1, w_issue0};
  assign ex_valid       = {w_issue1, w_issue0};
  assign ex_rd[0]       = w_h0.rd;
  assign ex_rd[1]       = w_h1.rd;
  assign ex_op[0]       = w_h0.op[OP_W-1:0];
  assign ex_op[1]       = w_h1.op[OP_W-1:0];

`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall_hazard;
  logic [31:0] r_perf_stall_struct;
  logic [32:0] w_issued_sum;
  logic        w_hazard_stall;
  logic        w_struct_stall;

  assign w_issued_sum   = {1'b0, r_perf_issued} + 33'(w_deq_n);
  assign w_hazard_stall = w_v0 && (sb_hazard[0] || (w_issue0 && w_v1 && (sb_hazard[1] || w_dep)));
  assign w_struct_stall = w_v0 && !sb_hazard[0] && !ex_ready[0];

  // All three counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issued       <= '0;
      r_perf_stall_hazard <= '0;
      r_perf_stall_struct <= '0;
    end else begin
      r_perf_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
      if (w_hazard_stall && r_perf_stall_hazard != '1) begin
        r_perf_stall_hazard <= r_perf_stall_hazard + 32'd1;
      end
      if (w_struct_stall && r_perf_stall_struct != '1) begin
        r_perf_stall_struct <= r_perf_stall_struct + 32'd1;
      end
    end
  end

  assign perf_issued       = r_perf_issued;
  assign perf_stall_hazard = r_perf_stall_hazard;
  assign perf_stall_struct = r_perf_stall_struct;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl (DEPTH=4, OP_W=32); expected values
// are hand-computed constants written next to each step.
module tb_issue_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [1:0]      in_valid;
  logic            in_ready;
  logic [1:0][4:0] in_rs1;
  logic [1:0][4:0] in_rs2;
  logic [1:0][4:0] in_rd;
  logic [1:0][31:0] in_op;
  logic [1:0]      sb_issue_valid;
  logic [1:0][4:0] sb_rs1;
  logic [1:0][4:0] sb_rs2;
  logic [1:0][4:0] sb_rd;
  logic [1:0]      sb_hazard;
  logic [1:0]      ex_valid;
  logic [1:0]      ex_ready;
  logic [1:0][4:0] ex_rd;
  logic [1:0][31:0] ex_op;
`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_stall_hazard;
  logic [31:0]     perf_stall_struct;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_ctrl #(
    .DEPTH (4),
    .OP_W  (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_op          (in_op),
    .sb_issue_valid (sb_issue_valid),
    .sb_rs1         (sb_rs1),
    .sb_rs2         (sb_rs2),
    .sb_rd          (sb_rd),
    .sb_hazard      (sb_hazard),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_rd          (ex_rd),
    .ex_op          (ex_op)
`ifdef ISSUE_CTRL_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_stall_hazard (perf_stall_hazard),
    .perf_stall_struct (perf_stall_struct)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [4:0] rd0, input logic [4:0] rs10, input logic [4:0] rs20,
                               input logic [4:0] rd1, input logic [4:0] rs11, input logic [4:0] rs21,
                               input logic [31:0] op0, input logic [31:0] op1);
    in_valid  = v;
    in_rd[0]  = rd0;
    in_rs1[0] = rs10;
    in_rs2[0] = rs20;
    in_rd[1]  = rd1;
    in_rs1[1] = rs11;
    in_rs2[1] = rs21;
    in_op[0]  = op0;
    in_op[1]  = op1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    sb_hazard = 2'b00;
    ex_ready  = 2'b00;
    idleInputs();

    // Reset state
    #3;
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("rst_sb_issue_valid", 32'(sb_issue_valid), 32'h0);
    checkOutput("rst_count", 32'(dut.w_count), 32'h0);
    #9;
    reset = 1'b0;
    tick();

    // Independent pair issues together one cycle after enqueue
    ex_ready = 2'b11;
    applyStimulus(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 32'hA0, 32'hA1);
    #1;
    checkOutput("indep_no_bypass", 32'(ex_valid), 32'h0);
    tick();
    idleInputs();
    #1;
    checkOutput("indep_ex_valid", 32'(ex_valid), 32'h3);
    checkOutput("indep_sb_issue_valid", 32'(sb_issue_valid), 32'h3);
    checkOutput("indep_ex_rd0", 32'(ex_rd[0]), 32'd1);
    checkOutput("indep_ex_rd1", 32'(ex_rd[1]), 32'd4);
    checkOutput("indep_ex_op1", ex_op[1], 32'hA1);
    checkOutput("indep_sb_rs1_1", 32'(sb_rs1[1]), 32'd5);
    checkOutput("indep_sb_rs2_0", 32'(sb_rs2[0]), 32'd3);
    tick();
    checkOutput("indep_count_after", 32'(dut.w_count), 32'h0);
    checkOutput("indep_empty_no_issue", 32'(ex_valid), 32'h0);

    // Intra-pair RAW: only slot 0 issues, then H1 moves to the head
    applyStimulus(2'b11, 5'd1, 5'd2, 5'd3, 5'd7, 5'd1, 5'd0, 32'hB0, 32'hB1);
    tick();
    idleInputs();
    #1;
    checkOutput("raw_ex_valid", 32'(ex_valid), 32'h1);
    checkOutput("raw_ex_rd0", 32'(ex_rd[0]), 32'd1);
    tick();
    sb_hazard = 2'b01;
    #1;
    checkOutput("raw_head_sb_rd0", 32'(sb_rd[0]), 32'd7);
    checkOutput("raw_head_sb_rs1_0", 32'(sb_rs1[0]), 32'd1);
    checkOutput("raw_head_stall", 32'(ex_valid), 32'h0);
    sb_hazard = 2'b00;
    #1;
    checkOutput("raw_head_issue", 32'(ex_valid), 32'h1);
    checkOutput("raw_head_op", ex_op[0], 32'hB1);
    tick();
    checkOutput("raw_count_after", 32'(dut.w_count), 32'h0);

    // Scoreboard hazards and execute readiness combinations
    applyStimulus(2'b11, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 32'hC0, 32'hC1);
    tick();
    idleInputs();
    sb_hazard = 2'b01;
    #1;
    checkOutput("haz01_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("haz01_sb_issue_valid", 32'(sb_issue_valid), 32'h0);
    sb_hazard = 2'b10;
    #1;
    checkOutput("haz10_ex_valid", 32'(ex_valid), 32'h1);
    sb_hazard = 2'b00;
    ex_ready  = 2'b01;
    #1;
    checkOutput("exrdy01_ex_valid", 32'(ex_valid), 32'h1);
    ex_ready = 2'b10;
    #1;
    checkOutput("exrdy10_ex_valid", 32'(ex_valid), 32'h0);
    ex_ready = 2'b11;
    #1;
    checkOutput("exrdy11_ex_valid", 32'(ex_valid), 32'h3);
    tick();
    checkOutput("haz_count_after", 32'(dut.w_count), 32'h0);

    // Fill to DEPTH and drain one at a time
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd16, 5'd0, 5'd0, 5'd17, 5'd0, 5'd0, 32'hD0, 32'hD1);
    tick();
    applyStimulus(2'b11, 5'd18, 5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 32'hD2, 32'hD3);
    #1;
    checkOutput("fill_count2", 32'(dut.w_count), 32'h2);
    checkOutput("fill_ready_at2", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(2'b11, 5'd30, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 32'hEE, 32'hEF);
    #1;
    checkOutput("full_count", 32'(dut.w_count), 32'h4);
    checkOutput("full_in_ready", 32'(in_ready), 32'h0);
    tick();
    idleInputs();
    ex_ready = 2'b01;
    #1;
    checkOutput("full_no_overwrite_count", 32'(dut.w_count), 32'h4);
    checkOutput("full_issue_one", 32'(ex_valid), 32'h1);
    checkOutput("full_head_rd", 32'(ex_rd[0]), 32'd16);
    tick();
    checkOutput("cnt3_count", 32'(dut.w_count), 32'h3);
    checkOutput("cnt3_in_ready", 32'(in_ready), 32'h0);
    checkOutput("cnt3_head_rd", 32'(ex_rd[0]), 32'd17);
    tick();
    checkOutput("cnt2_in_ready", 32'(in_ready), 32'h1);
    ex_ready = 2'b11;
    #1;
    checkOutput("drain_rd0", 32'(ex_rd[0]), 32'd18);
    checkOutput("drain_rd1", 32'(ex_rd[1]), 32'd19);
    tick();
    checkOutput("drain_count", 32'(dut.w_count), 32'h0);

    // Steady state: enqueue 2 and dequeue 2 at count=2 across several wraps
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'h100, 32'h101);
    tick();
    ex_ready = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(2'b11, 5'(2*k+1), 5'd0, 5'd0, 5'(2*k+2), 5'd0, 5'd0,
                    32'h100 + 32'(2*k), 32'h101 + 32'(2*k));
      #1;
      checkOutput("steady_ex_valid", 32'(ex_valid), 32'h3);
      checkOutput("steady_rd0", 32'(ex_rd[0]), 32'(2*k - 1));
      checkOutput("steady_op1", ex_op[1], 32'h101 + 32'(2*k - 2));
      tick();
      checkOutput("steady_count", 32'(dut.w_count), 32'h2);
    end
    idleInputs();
    #1;
    checkOutput("steady_last_rd0", 32'(ex_rd[0]), 32'd13);
    checkOutput("steady_last_rd1", 32'(ex_rd[1]), 32'd14);
    tick();
    checkOutput("steady_drained", 32'(dut.w_count), 32'h0);

    // Flush at count=3 blocks issue and enqueue, then empties the buffer
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd20, 5'd0, 5'd0, 5'd21, 5'd0, 5'd0, 32'hF0, 32'hF1);
    tick();
    applyStimulus(2'b01, 5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'hF2, 32'h0);
    tick();
    checkOutput("flush_pre_count", 32'(dut.w_count), 32'h3);
    ex_ready = 2'b11;
    flush    = 1'b1;
    applyStimulus(2'b11, 5'd23, 5'd0, 5'd0, 5'd24, 5'd0, 5'd0, 32'hF3, 32'hF4);
    #1;
    checkOutput("flush_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("flush_sb_issue_valid", 32'(sb_issue_valid), 32'h0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    idleInputs();
    #1;
    checkOutput("post_flush_count", 32'(dut.w_count), 32'h0);
    checkOutput("post_flush_in_ready", 32'(in_ready), 32'h1);
    checkOutput("post_flush_ex_valid", 32'(ex_valid), 32'h0);

    // rd=x0 never creates a dependency; WAW on a nonzero rd does
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd0, 5'd1, 5'd2, 5'd9, 5'd0, 5'd0, 32'h50, 32'h51);
    tick();
    idleInputs();
    ex_ready = 2'b11;
    #1;
    checkOutput("x0_no_dep", 32'(ex_valid), 32'h3);
    tick();
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd5, 5'd1, 5'd2, 5'd5, 5'd3, 5'd4, 32'h60, 32'h61);
    tick();
    idleInputs();
    ex_ready = 2'b11;
    #1;
    checkOutput("waw_dep", 32'(ex_valid), 32'h1);
    tick();
    checkOutput("waw_second", 32'(ex_valid), 32'h1);
    checkOutput("waw_second_op", ex_op[0], 32'h61);
    tick();

    // Asynchronous reset mid-stream
    ex_ready = 2'b00;
    applyStimulus(2'b11, 5'd25, 5'd0, 5'd0, 5'd26, 5'd0, 5'd0, 32'h70, 32'h71);
    tick();
    idleInputs();
    ex_ready = 2'b11;
    #1;
    checkOutput("prereset_ex_valid", 32'(ex_valid), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("midreset_sb_issue_valid", 32'(sb_issue_valid), 32'h0);
    checkOutput("midreset_count", 32'(dut.w_count), 32'h0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'h1);
`ifdef ISSUE_CTRL_PERF_EN
    checkOutput("midreset_perf_issued", perf_issued, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("postreset_ex_valid", 32'(ex_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
